// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   BYTE_W          : width of one transmitted byte
//   DEF_*           : default arbiter parameters
//   state_t         : arbiter FSM state encoding
package uart_ctrl_pkg;

   localparam int BYTE_W         = 8;
   localparam int DEF_N_REQ      = 4;
   localparam int DEF_TIMEOUT    = 16;
   localparam int DEF_GAP_CYCLES = 0;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACT  = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector
//   ptr        : index of the last granted requester
//   gnt_onehot : one-hot winner
//   gnt_idx    : index of the winner
//   gnt_valid  : at least one request present
// The scan starts at (ptr+1) mod N_REQ and wraps, so the last winner has
// the lowest priority on the next pick.
module rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic [IW-1:0]    gnt_idx,
   output logic             gnt_valid
);

   int          start_idx;
   logic [IW-1:0] idx;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      gnt_valid  = 1'b0;
      idx        = '0;
      start_idx  = (int'(ptr) >= N_REQ - 1) ? 0 : int'(ptr) + 1;
      for (int i = 0; i < N_REQ; i++) begin
         idx = IW'((start_idx + i) % N_REQ);
         if (!gnt_valid && req[idx]) begin
            gnt_valid       = 1'b1;
            gnt_idx         = idx;
            gnt_onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ byte sources.
//   clk, reset   : clock, asynchronous active-high reset
//   req          : per-requester level request, held until ack
//   req_data     : byte of requester i at [8i+7:8i]
//   ack          : one-cycle pulse, byte of requester i latched
//   tx_data_out  : byte presented to the transmitter
//   tx_start     : one-cycle start pulse to the transmitter
//   tx_active    : transmitter busy flag for the whole frame
//   grant_id     : index of the current/last granted requester
//   busy         : high whenever the FSM is not idle
//   done         : one-cycle pulse at frame completion
//   timeout_err  : one-cycle pulse when tx_active never rose in time
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter  int N_REQ      = DEF_N_REQ,
   parameter  int TIMEOUT    = DEF_TIMEOUT,
   parameter  int GAP_CYCLES = DEF_GAP_CYCLES,
   localparam int IW         = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [BYTE_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]        ack,
   output logic [BYTE_W-1:0]       tx_data_out,
   output logic                    tx_start,
   input  logic                    tx_active,
   output logic [IW-1:0]           grant_id,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout_err
);

   localparam int MAXC = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [N_REQ-1:0] win_onehot;
   logic [IW-1:0]    win_idx;
   logic             win_valid;
   logic [BYTE_W-1:0] data_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[g*BYTE_W +: BYTE_W];
   end

   // grant_id doubles as the round-robin pointer; a timed-out frame has
   // already moved it, so a dead requester cannot starve the others.
   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req        (req),
      .ptr        (grant_id),
      .gnt_onehot (win_onehot),
      .gnt_idx    (win_idx),
      .gnt_valid  (win_valid)
   );

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         ack         <= '0;
         tx_start    <= 1'b0;
         tx_data_out <= '0;
         grant_id    <= IW'(N_REQ - 1);
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         ack         <= '0;
         tx_start    <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  tx_data_out <= data_arr[win_idx];
                  grant_id    <= win_idx;
                  ack         <= win_onehot;
                  tx_start    <= 1'b1;
                  cnt         <= '0;
                  state       <= ST_WAIT_ACT;
               end
            end
            ST_WAIT_ACT: begin
               if (tx_active) begin
                  cnt   <= '0;
                  state <= ST_WAIT_DONE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  cnt         <= '0;
                  state       <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_active) begin
                  done  <= 1'b1;
                  cnt   <= '0;
                  state <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
               end
            end
            ST_GAP: begin
               // the cycle carrying done counts as the first gap cycle
               if (cnt == CW'(GAP_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with GAP_CYCLES=0 and
// one with GAP_CYCLES=3 for the inter-frame gap timing.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic        tx_active = 1'b0;
   logic [3:0]  ack;
   logic [7:0]  tx_data_out;
   logic        tx_start;
   logic [1:0]  grant_id;
   logic        busy, done, timeout_err;

   logic [3:0]  req_g = '0;
   logic [31:0] req_data_g = 32'hD4C3B2A1;
   logic        tx_active_g = 1'b0;
   logic [3:0]  ack_g;
   logic [7:0]  tx_data_out_g;
   logic        tx_start_g;
   logic [1:0]  grant_id_g;
   logic        busy_g, done_g, timeout_err_g;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16), .GAP_CYCLES(0)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
      .tx_data_out(tx_data_out), .tx_start(tx_start), .tx_active(tx_active),
      .grant_id(grant_id), .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16), .GAP_CYCLES(3)) dut_g (
      .clk(clk), .reset(reset), .req(req_g), .req_data(req_data_g), .ack(ack_g),
      .tx_data_out(tx_data_out_g), .tx_start(tx_start_g), .tx_active(tx_active_g),
      .grant_id(grant_id_g), .busy(busy_g), .done(done_g), .timeout_err(timeout_err_g)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Waits for the grant, checks it, runs an act_len-cycle frame, checks done.
   task automatic run_frame(input int exp_id, input int act_len);
      int n;
      int acks;
      n = 0;
      do begin
         tick();
         n++;
      end while (!tx_start && n < 20);
      chk($sformatf("f%0d_start_seen", exp_id), 32'(tx_start), 32'd1);
      chk($sformatf("f%0d_ack", exp_id), 32'(ack), 32'(4'b0001 << exp_id));
      chk($sformatf("f%0d_gid", exp_id), 32'(grant_id), 32'(exp_id));
      chk($sformatf("f%0d_data", exp_id), 32'(tx_data_out), 32'(req_data[exp_id*8 +: 8]));
      acks = 0;
      tx_active = 1'b1;
      for (int k = 0; k < act_len; k++) begin
         tick();
         acks += $countones(ack);
      end
      tx_active = 1'b0;
      tick();
      acks += $countones(ack);
      chk($sformatf("f%0d_extra_acks", exp_id), 32'(acks), 32'd0);
      chk($sformatf("f%0d_done", exp_id), 32'(done), 32'd1);
   endtask

   initial begin
      int cnt_a, cnt_b, cnt_c, n;

      // reset state
      tick();
      tick();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_start", 32'(tx_start), 32'd0);
      chk("rst_data", 32'(tx_data_out), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      reset = 1'b0;

      // single requester 2, byte A5
      req_data = 32'h44A52211;
      req = 4'b0100;
      tick();
      chk("s_ack", 32'(ack), 32'h4);
      chk("s_start", 32'(tx_start), 32'd1);
      chk("s_data", 32'(tx_data_out), 32'hA5);
      chk("s_gid", 32'(grant_id), 32'd2);
      chk("s_busy", 32'(busy), 32'd1);
      req = 4'b0000;
      tick();
      chk("s_ack_off", 32'(ack), 32'd0);
      chk("s_start_off", 32'(tx_start), 32'd0);
      tx_active = 1'b1;
      cnt_a = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         cnt_a += int'(done);
      end
      tx_active = 1'b0;
      tick();
      chk("s_done", 32'(done), 32'd1);
      chk("s_idle", 32'(busy), 32'd0);
      cnt_a += int'(done);
      tick();
      cnt_a += int'(done);
      chk("s_done_count", 32'(cnt_a), 32'd1);
      chk("s_data_hold", 32'(tx_data_out), 32'hA5);

      // all requesters held: round-robin order 0,1,2,3,0
      do_reset();
      req_data = 32'h44332211;
      req = 4'b1111;
      run_frame(0, 3);
      run_frame(1, 2);
      run_frame(2, 4);
      run_frame(3, 1);
      run_frame(0, 2);
      req = 4'b0000;

      // timeout: tx_active never rises
      do_reset();
      req_data = 32'h99887766;
      req = 4'b0010;
      tick();
      chk("t_gid", 32'(grant_id), 32'd1);
      chk("t_start", 32'(tx_start), 32'd1);
      req = 4'b1001;
      cnt_a = 0;
      cnt_b = 0;
      cnt_c = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k < 16) cnt_a += int'(timeout_err);
         cnt_b += int'(done);
         cnt_c += int'(tx_start);
      end
      chk("t_terr", 32'(timeout_err), 32'd1);
      chk("t_terr_early", 32'(cnt_a), 32'd0);
      chk("t_no_done", 32'(cnt_b), 32'd0);
      chk("t_no_start", 32'(cnt_c), 32'd0);
      chk("t_idle", 32'(busy), 32'd0);
      tick();
      chk("t_next_gid", 32'(grant_id), 32'd3);
      chk("t_next_ack", 32'(ack), 32'h8);
      chk("t_next_data", 32'(tx_data_out), 32'h99);
      chk("t_terr_off", 32'(timeout_err), 32'd0);

      // reset in WAIT_DONE
      do_reset();
      req = 4'b0100;
      tick();
      chk("r_gid", 32'(grant_id), 32'd2);
      req = 4'b0000;
      tx_active = 1'b1;
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("r_async_data", 32'(tx_data_out), 32'd0);
      chk("r_async_busy", 32'(busy), 32'd0);
      chk("r_async_gid", 32'(grant_id), 32'd3);
      chk("r_async_done", 32'(done), 32'd0);
      tx_active = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("r_held_done", 32'(done), 32'd0);
      tick();
      chk("r_no_grant", 32'(tx_start), 32'd0);
      chk("r_no_busy", 32'(busy), 32'd0);
      req = 4'b0010;
      tick();
      chk("r_first_gid", 32'(grant_id), 32'd1);
      chk("r_first_ack", 32'(ack), 32'h2);
      req = 4'b0000;

      // req[3] pulsed only while busy
      cnt_a = 0;
      req = 4'b1000;
      tick();
      cnt_a += int'(tx_start) + int'(ack[3]);
      tick();
      cnt_a += int'(tx_start) + int'(ack[3]);
      req = 4'b0000;
      tx_active = 1'b1;
      tick();
      tick();
      tx_active = 1'b0;
      tick();
      chk("p_done", 32'(done), 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         cnt_a += int'(tx_start) + int'(ack[3]);
      end
      chk("p_no_grant", 32'(cnt_a), 32'd0);

      // GAP_CYCLES=3: next start 4 cycles after done
      req_g = 4'b0011;
      n = 0;
      do begin
         tick();
         n++;
      end while (!tx_start_g && n < 20);
      chk("g_start_seen", 32'(tx_start_g), 32'd1);
      chk("g_gid0", 32'(grant_id_g), 32'd0);
      chk("g_data0", 32'(tx_data_out_g), 32'hA1);
      tx_active_g = 1'b1;
      tick();
      tick();
      tx_active_g = 1'b0;
      tick();
      chk("g_done", 32'(done_g), 32'd1);
      chk("g_busy_gap", 32'(busy_g), 32'd1);
      n = 0;
      do begin
         tick();
         n++;
      end while (!tx_start_g && n < 10);
      chk("g_gap_len", 32'(n), 32'd4);
      chk("g_gid1", 32'(grant_id_g), 32'd1);
      chk("g_ack1", 32'(ack_g), 32'h2);
      req_g = 4'b0000;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
